alu4_arbiter: RTL and testbench
===============================

Name: alu4_arbiter

Overview:
Shares one combinational 4-bit ALU (3-bit op; flags C/N/Z/V) between two requesters.
- Arbitrates round-robin, registers the winning operands into the ALU inputs, and captures result plus flags one cycle later.
- Returns them on a single tagged response channel with valid/ready backpressure.
- Sits between the two operand sources (e.g. a sequencer and a host port) and the shared ALU instance.

Parameters:
RR_INIT, 0, requester holding priority after reset (0 or 1)
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 transfer accepted this cycle
req0_op  input  3  requester 0 ALU op
req0_a  input  4  requester 0 operand A
req0_b  input  4  requester 0 operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
alu_op  output  3  op driven to shared ALU
alu_a  output  4  operand A to ALU
alu_b  output  4  operand B to ALU
alu_result  input  4  ALU result
alu_c, alu_n, alu_z, alu_v  input  1 each  ALU flags
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the op
rsp_result  output  4  captured result
rsp_c, rsp_n, rsp_z, rsp_v  output  1 each  captured flags
busy  output  1  state != IDLE
op_count  output  CNT_W  completed responses, wraps

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n). All state resets immediately on reset_n=0, independent of clk.
- Reset values:
  - state=IDLE; alu_op=000, alu_a=0, alu_b=0.
  - rsp_* = 0, rsp_valid=0, busy=0, op_count=0.
  - priority pointer = RR_INIT.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If neither valid: stay.
  - If one valid: grant it.
  - If both valid: grant the requester named by the priority pointer.
  - reqX_ready is combinational: 1 only in IDLE, only for the granted requester. The transfer happens that cycle.
  - On transfer: register op/a/b into alu_op/alu_a/alu_b; latch id; set pointer to the other requester; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* stable.
  - At the clock edge, capture alu_result/c/n/z/v into rsp_*; rsp_id=latched id; go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_* held stable until rsp_ready=1. On that edge: rsp_valid=0, op_count+=1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
  - Both req ready=0 throughout EXEC and RESP.
- Latency: request accept -> rsp_valid is 2 edges. Maximum throughput is one op per 3 cycles with rsp_ready held 1.
- alu_* keep their last issued values while in IDLE and RESP; they change only on a transfer.
- op is passed to the ALU unmodified. All 8 codes are legal. Flags are whatever the ALU reports; C and V are 0 for non-add/sub ops, per ALU definition.
- Pointer updates only on a grant, so a lone requester never loses priority it does not use. Starvation-free: a waiting requester is served within one other transaction.
- reqX_valid deasserted while not ready: no effect, no transfer.
- Reset asserted mid-EXEC or mid-RESP: the transaction is discarded, no response is produced, op_count is not incremented.
- busy = (state != IDLE).

Test Plan:
- Add, requester 0: after reset, req0 op=110, a=0111, b=0001 -> req0_ready=1 same cycle; rsp_valid 2 edges later with rsp_id=0, result=1000, c=0, n=1, z=0, v=1; op_count=1 after rsp_ready.
- Subtract, requester 1: op=111, a=0011, b=0011 -> result=0000, z=1, c=1, v=0, n=0, rsp_id=1.
- Contention: RR_INIT=0, both valid held continuously, rsp_ready=1 -> grants alternate 0,1,0,1 at 3-cycle spacing; each rsp_id matches the issuing requester's operands.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_* constant, both req ready=0, busy=1; releasing rsp_ready returns to IDLE next edge.
- Reset mid-operation: assert reset_n=0 during EXEC -> all outputs at reset values immediately, no response, op_count=0, pointer=RR_INIT.
- Counter wrap: CNT_W=8, complete 256 ops -> op_count reads 255 then 0.

Source files
------------

// File: rtl/alu4_arbiter_if.sv
// rtl/alu4_arbiter_if.sv - bus bundle between two requesters, the shared ALU and the response consumer
//
// Purpose: groups every handshake/data signal of alu4_arbiter so the block
// connects through one interface port.
// Modports:
//   slave  - arbiter side: takes requests and ALU results, drives grants,
//            ALU operands, the tagged response, busy and op_count
//   master - environment side: requesters, ALU and response consumer
interface alu4_arbiter_if #(
  parameter int CNT_W = 8
) ();
  // requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  // requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  // shared ALU
  logic [2:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_result;
  logic             alu_c;
  logic             alu_n;
  logic             alu_z;
  logic             alu_v;
  // tagged response
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [3:0]       rsp_result;
  logic             rsp_c;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_v;
  // status
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_c, alu_n, alu_z, alu_v,
    output rsp_valid, rsp_id, rsp_result, rsp_c, rsp_n, rsp_z, rsp_v,
    input  rsp_ready,
    output busy, op_count
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_c, alu_n, alu_z, alu_v,
    input  rsp_valid, rsp_id, rsp_result, rsp_c, rsp_n, rsp_z, rsp_v,
    output rsp_ready,
    input  busy, op_count
  );
endinterface

// File: rtl/alu4_arbiter.sv
// rtl/alu4_arbiter.sv - round-robin sharing of one 4-bit ALU between two requesters
//
// Purpose: grants one of two requesters in IDLE, registers its op/operands
// into the shared ALU, captures result and flags after one EXEC cycle and
// presents them on a tagged valid/ready response channel.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - alu4_arbiter_if.slave: req0/req1 handshakes, ALU operands and
//             results, rsp channel, busy, op_count
module alu4_arbiter #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  alu4_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_id;
  logic [2:0]       r_alu_op;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic             r_rsp_id;
  logic [3:0]       r_rsp_result;
  logic             r_rsp_c;
  logic             r_rsp_n;
  logic             r_rsp_z;
  logic             r_rsp_v;
  logic [CNT_W-1:0] r_op_count;
  logic             w_take;
  logic             w_grant_id;
  logic             w_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Contention resolves by the pointer; a lone requester is granted directly
  // without consulting it, so unused priority is never lost.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_grant_id  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_take      = 1'b1;
          w_grant_id  = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= RR_INIT;
      r_id         <= 1'b0;
      r_alu_op     <= 3'b000;
      r_alu_a      <= 4'h0;
      r_alu_b      <= 4'h0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 4'h0;
      r_rsp_c      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_z      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_take) begin
        r_alu_op <= w_grant_id ? bus.req1_op : bus.req0_op;
        r_alu_a  <= w_grant_id ? bus.req1_a  : bus.req0_a;
        r_alu_b  <= w_grant_id ? bus.req1_b  : bus.req0_b;
        r_id     <= w_grant_id;
        r_ptr    <= ~w_grant_id;
      end
      // ALU is combinational on the registered operands, so its outputs
      // are settled by the end of the single EXEC cycle.
      if (r_state == S_EXEC) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= bus.alu_result;
        r_rsp_c      <= bus.alu_c;
        r_rsp_n      <= bus.alu_n;
        r_rsp_z      <= bus.alu_z;
        r_rsp_v      <= bus.alu_v;
      end
      if (w_done) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_take & ~w_grant_id;
  assign bus.req1_ready = w_take &  w_grant_id;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_n      = r_rsp_n;
  assign bus.rsp_z      = r_rsp_z;
  assign bus.rsp_v      = r_rsp_v;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu4_arbiter.sv
// tb/tb_alu4_arbiter.sv - directed self-checking bench for alu4_arbiter
module tb_alu4_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [4:0] alu_s;

  always #5 clk = ~clk;

  alu4_arbiter_if #(.CNT_W(8)) bus ();

  alu4_arbiter #(.RR_INIT(1'b0), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference ALU: 110 add, 111 sub (C = no borrow), others logic with C=V=0.
  always_comb begin
    alu_s          = 5'd0;
    bus.alu_result = 4'h0;
    bus.alu_c      = 1'b0;
    bus.alu_v      = 1'b0;
    case (bus.alu_op)
      3'b000: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b011: bus.alu_result = ~bus.alu_a;
      3'b100: bus.alu_result = {bus.alu_a[2:0], 1'b0};
      3'b101: bus.alu_result = {1'b0, bus.alu_a[3:1]};
      3'b110: begin
        alu_s          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = alu_s[3:0];
        bus.alu_c      = alu_s[4];
        bus.alu_v      = (bus.alu_a[3] == bus.alu_b[3]) && (alu_s[3] != bus.alu_a[3]);
      end
      default: begin
        alu_s          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        bus.alu_result = alu_s[3:0];
        bus.alu_c      = alu_s[4];
        bus.alu_v      = (bus.alu_a[3] != bus.alu_b[3]) && (alu_s[3] != bus.alu_a[3]);
      end
    endcase
  end
  assign bus.alu_n = bus.alu_result[3];
  assign bus.alu_z = (bus.alu_result == 4'h0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [3:0] res,
                           input logic c, input logic n, input logic z, input logic v);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_res"}, 32'(bus.rsp_result), 32'(res));
    check({tag, "_cnzv"}, 32'({bus.rsp_c, bus.rsp_n, bus.rsp_z, bus.rsp_v}), 32'({c, n, z, v}));
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.rsp_ready  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    check("rst_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
    check("rst_rsp", 32'({bus.rsp_id, bus.rsp_result, bus.rsp_c, bus.rsp_n, bus.rsp_z, bus.rsp_v}), 32'd0);
    reset_n = 1'b1;

    // add on requester 0: 7 + 1 = 8, N=1, V=1
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 3'b110; bus.req0_a = 4'b0111; bus.req0_b = 4'b0001;
    #1;
    check("add_ready0", 32'(bus.req0_ready), 32'd1);
    check("add_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("add_exec_busy", 32'(bus.busy), 32'd1);
    check("add_exec_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({3'b110, 4'b0111, 4'b0001}));
    check("add_exec_novalid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_rsp("add", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("add_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("add_done_count", 32'(bus.op_count), 32'd1);

    // subtract on requester 1: 3 - 3 = 0, Z=1, C=1, plus backpressure
    bus.req1_valid = 1'b1; bus.req1_op = 3'b111; bus.req1_a = 4'b0011; bus.req1_b = 4'b0011;
    #1;
    check("sub_ready1", 32'(bus.req1_ready), 32'd1);
    check("sub_ready0", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    check("sub_exec_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({3'b111, 4'b0011, 4'b0011}));
    @(negedge clk);
    check_rsp("sub", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_rsp("bp", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    check("bp_rel_busy", 32'(bus.busy), 32'd0);
    check("bp_rel_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_rel_count", 32'(bus.op_count), 32'd2);

    // contention: pointer is 0 after the requester-1 grant; expect 0,1,0,1
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'hC; bus.req0_b = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b010; bus.req1_a = 4'hC; bus.req1_b = 4'hA;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'({bus.req1_ready, bus.req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      @(negedge clk);
      if (k % 2 == 0) check_rsp("rr0", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
      else            check_rsp("rr1", 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("rr_count", 32'(bus.op_count), 32'd6);
    bus.req1_valid = 1'b0;

    // reset during EXEC: req0 alone moves pointer to 1, then reset discards
    bus.req0_op = 3'b110; bus.req0_a = 4'b0111; bus.req0_b = 4'b0001;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("mid_exec_busy", 32'(bus.busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
    check("mid_rst_count", 32'(bus.op_count), 32'd0);
    @(negedge clk);
    check("mid_rst_norsp", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("mid_rst_ptr", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    bus.req1_valid = 1'b0;

    // counter wrap: req0 held valid, rsp_ready held 1, one op per 3 cycles
    repeat (765) @(negedge clk);
    check("wrap_255", 32'(bus.op_count), 32'd255);
    repeat (3) @(negedge clk);
    check("wrap_0", 32'(bus.op_count), 32'd0);
    bus.req0_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
